// File: rtl/de0qsys_hex_ctrl_pkg.sv
// Shared constants for the DE0 QSYS hex display controller: register map,
// CTRL bit positions and the active-low seven-segment decode table.
package de0qsys_hex_ctrl_pkg;

    // Avalon-MM word addresses
    localparam logic [1:0] ADDR_VALUE = 2'd0;
    localparam logic [1:0] ADDR_CTRL  = 2'd1;
    localparam logic [1:0] ADDR_DIV   = 2'd2;
    localparam logic [1:0] ADDR_CMD   = 2'd3;

    // CTRL register layout
    localparam int CTRL_BLANK_LSB = 0;
    localparam int CTRL_DP_LSB    = 4;
    localparam int CTRL_BLINK_LSB = 8;
    localparam int CTRL_AUTO_BIT  = 12;
    localparam int CTRL_W         = 13;

    // Segment codes, active-low, bit 7 = dp
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Nibble -> {g,f,e,d,c,b,a}, active-low. Element 15 is listed first.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
        7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
    };

endpackage

// File: rtl/de0qsys_hex7seg.sv
// Combinational nibble to active-low seven-segment decoder.
module de0qsys_hex7seg
    import de0qsys_hex_ctrl_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    assign o_seg = SEG_TABLE[i_nibble];

endmodule

// File: rtl/de0qsys_hex_ctrl.sv
// Avalon-MM slave driving four seven-segment digits. VALUE and CTRL are
// written into shadow registers and copied to the active set on commit;
// the blink divider is live. Segment outputs are registered.
module de0qsys_hex_ctrl
    import de0qsys_hex_ctrl_pkg::*;
#(
    parameter logic [23:0] BLINK_DIV_RST = 24'd12_500_000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [7:0]  hex0,
    output logic [7:0]  hex1,
    output logic [7:0]  hex2,
    output logic [7:0]  hex3
);

    logic [15:0]       r_value_sh;
    logic [15:0]       r_value_act;
    logic [CTRL_W-1:0] r_ctrl_sh;
    logic [CTRL_W-1:0] r_ctrl_act;
    logic [23:0]       r_blink_div;
    logic [23:0]       r_cnt;
    logic              r_phase;
    logic              r_pending;
    logic [3:0][7:0]   r_hex;

    logic              w_wr;
    logic              w_wr_val;
    logic              w_wr_ctrl;
    logic              w_wr_div;
    logic              w_wr_cmd;
    logic              w_commit;
    logic [15:0]       w_value_new;
    logic [CTRL_W-1:0] w_ctrl_new;
    logic [3:0][6:0]   w_seg;
    logic [3:0][7:0]   w_hex_nxt;

    // Decode the bus write and work out whether this edge commits. Auto-commit
    // follows the auto bit already held in the shadow CTRL; the commit always
    // carries the data being written on the same edge.
    always_comb begin
        w_wr        = chipselect & ~write_n;
        w_wr_val    = w_wr && (address == ADDR_VALUE);
        w_wr_ctrl   = w_wr && (address == ADDR_CTRL);
        w_wr_div    = w_wr && (address == ADDR_DIV);
        w_wr_cmd    = w_wr && (address == ADDR_CMD);
        w_commit    = ((w_wr_val | w_wr_ctrl) & r_ctrl_sh[CTRL_AUTO_BIT])
                    | (w_wr_cmd & writedata[0]);
        w_value_new = w_wr_val  ? writedata[15:0]       : r_value_sh;
        w_ctrl_new  = w_wr_ctrl ? writedata[CTRL_W-1:0] : r_ctrl_sh;
    end

    // Shadow, active and pending registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_value_sh  <= '0;
            r_ctrl_sh   <= '0;
            r_value_act <= '0;
            r_ctrl_act  <= '0;
            r_pending   <= 1'b0;
        end else begin
            r_value_sh <= w_value_new;
            r_ctrl_sh  <= w_ctrl_new;
            if (w_commit) begin
                r_value_act <= w_value_new;
                r_ctrl_act  <= w_ctrl_new;
                r_pending   <= 1'b0;
            end else if (w_wr_val | w_wr_ctrl) begin
                r_pending   <= 1'b1;
            end
        end
    end

    // Blink divider: a divider write restarts the count and phase, a zero
    // divider parks the counter, otherwise wrap at div-1 and toggle phase.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_blink_div <= BLINK_DIV_RST;
            r_cnt       <= '0;
            r_phase     <= 1'b0;
        end else if (w_wr_div) begin
            r_blink_div <= writedata[23:0];
            r_cnt       <= '0;
            r_phase     <= 1'b0;
        end else if (r_blink_div == 24'd0) begin
            r_cnt       <= '0;
            r_phase     <= 1'b0;
        end else if (r_cnt >= r_blink_div - 24'd1) begin
            r_cnt       <= '0;
            r_phase     <= ~r_phase;
        end else begin
            r_cnt       <= r_cnt + 24'd1;
        end
    end

    // One decoder per digit, fed from the active value
    for (genvar g = 0; g < 4; g++) begin : g_digit
        de0qsys_hex7seg u_dec (
            .i_nibble (r_value_act[4*g +: 4]),
            .o_seg    (w_seg[g])
        );
    end

    // Next segment pattern: blank wins, blink blanks during phase 1
    always_comb begin
        w_hex_nxt = '0;
        for (int n = 0; n < 4; n++) begin
            if (r_ctrl_act[CTRL_BLANK_LSB + n] |
                (r_ctrl_act[CTRL_BLINK_LSB + n] & r_phase)) begin
                w_hex_nxt[n] = SEG_BLANK;
            end else begin
                w_hex_nxt[n] = {~r_ctrl_act[CTRL_DP_LSB + n], w_seg[n]};
            end
        end
    end

    // Registered segment outputs, all blank while in reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hex <= {4{SEG_BLANK}};
        end else begin
            r_hex <= w_hex_nxt;
        end
    end

    assign hex0 = r_hex[0];
    assign hex1 = r_hex[1];
    assign hex2 = r_hex[2];
    assign hex3 = r_hex[3];

    // Zero-wait-state read mux, independent of chipselect
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_VALUE: readdata = {16'b0, r_value_sh};
            ADDR_CTRL:  readdata = {{(32-CTRL_W){1'b0}}, r_ctrl_sh};
            ADDR_DIV:   readdata = {8'b0, r_blink_div};
            default:    readdata = {30'b0, r_phase, r_pending};
        endcase
    end

endmodule

// File: tb/tb_de0qsys_hex_ctrl.sv
// Directed bench for de0qsys_hex_ctrl. Inputs change on the falling edge,
// outputs are sampled on the falling edge (or 1ns after it for reads).
module tb_de0qsys_hex_ctrl;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  hex0;
    logic [7:0]  hex1;
    logic [7:0]  hex2;
    logic [7:0]  hex3;

    int total = 0;
    int bad   = 0;

    de0qsys_hex_ctrl dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .hex0       (hex0),
        .hex1       (hex1),
        .hex2       (hex2),
        .hex3       (hex3)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Entered at a falling edge; one write occupies exactly one rising edge
    // and returns at the following falling edge.
    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
        address = a;
        #1;
        chk(tag, readdata, exp);
    endtask

    task automatic chk_hex(input string tag, input logic [7:0] e3, input logic [7:0] e2,
                           input logic [7:0] e1, input logic [7:0] e0);
        chk({tag, "_hex3"}, {24'b0, hex3}, {24'b0, e3});
        chk({tag, "_hex2"}, {24'b0, hex2}, {24'b0, e2});
        chk({tag, "_hex1"}, {24'b0, hex1}, {24'b0, e1});
        chk({tag, "_hex0"}, {24'b0, hex0}, {24'b0, e0});
    endtask

    initial begin
        logic [7:0] e_h0;
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;

        // Reset: outputs blank, registers at reset values
        repeat (3) @(negedge clk);
        chk_hex("rst", 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        rd("rst_status", 2'd3, 32'h0);
        reset_n = 1'b1;
        @(negedge clk);
        chk_hex("rel", 8'hC0, 8'hC0, 8'hC0, 8'hC0);
        rd("rel_div", 2'd2, 32'h00BE_BC20);
        rd("rel_ctrl", 2'd1, 32'h0);

        // Shadowed value write, then explicit commit
        wr(2'd0, 32'h0000_1234);
        chk("nocommit_hex0", {24'b0, hex0}, 32'hC0);
        rd("pending_set", 2'd3, 32'h1);
        rd("value_sh", 2'd0, 32'h1234);
        @(negedge clk);
        chk("still_old_hex3", {24'b0, hex3}, 32'hC0);
        wr(2'd3, 32'h1);
        chk("lat_hex0", {24'b0, hex0}, 32'hC0);
        rd("pending_clr", 2'd3, 32'h0);
        @(negedge clk);
        chk_hex("commit", 8'hF9, 8'hA4, 8'hB0, 8'h99);

        // Enable auto-commit; that write itself only lands in the shadow
        wr(2'd1, 32'h0000_1000);
        rd("ctrl_pending", 2'd3, 32'h1);
        wr(2'd0, 32'h0000_ABCD);
        chk("auto_lat_hex0", {24'b0, hex0}, 32'h99);
        rd("auto_pending", 2'd3, 32'h0);
        @(negedge clk);
        chk_hex("auto", 8'h88, 8'h83, 8'hC6, 8'hA1);

        // Blink digit 0 with divider 4; divider written on edge E0
        wr(2'd2, 32'd4);
        wr(2'd1, 32'h0000_1100);
        for (int k = 2; k <= 13; k++) begin
            @(negedge clk);
            e_h0 = ((((k - 1) / 4) % 2) == 1) ? 8'hFF : 8'hA1;
            chk($sformatf("blink_h0_k%0d", k), {24'b0, hex0}, {24'b0, e_h0});
            chk($sformatf("blink_h1_k%0d", k), {24'b0, hex1}, 32'hC6);
            rd($sformatf("blink_ph_k%0d", k), 2'd3, (((k / 4) % 2) == 1) ? 32'h2 : 32'h0);
        end

        // Divider to zero while phase is 1
        wr(2'd2, 32'd0);
        rd("div0_phase", 2'd3, 32'h0);
        chk("div0_old_h0", {24'b0, hex0}, 32'hFF);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("div0_steady_%0d", k), {24'b0, hex0}, 32'hA1);
            rd($sformatf("div0_ph_%0d", k), 2'd3, 32'h0);
        end

        // Blank digits 0/2, decimal points on digits 1/3
        wr(2'd1, 32'h0000_10A5);
        @(negedge clk);
        chk_hex("blank_dp", 8'h08, 8'hFF, 8'h46, 8'hFF);

        // Unmapped bits are dropped
        wr(2'd1, 32'hFFFF_F0A5);
        rd("ctrl_mask", 2'd1, 32'h0000_10A5);
        wr(2'd2, 32'hFF12_3456);
        rd("div_mask", 2'd2, 32'h0012_3456);
        wr(2'd0, 32'hFFFF_ABCD);
        rd("value_mask", 2'd0, 32'h0000_ABCD);

        // Leave a pending value, then reset asynchronously mid-cycle
        wr(2'd1, 32'h0000_0000);
        wr(2'd0, 32'h0000_5555);
        rd("pre_rst_pending", 2'd3, 32'h1);
        chk_hex("pre_rst", 8'h88, 8'h83, 8'hC6, 8'hA1);
        #2;
        reset_n = 1'b0;
        #1;
        chk_hex("async_rst", 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        rd("rst_value", 2'd0, 32'h0);
        rd("rst_status2", 2'd3, 32'h0);
        rd("rst_div", 2'd2, 32'h00BE_BC20);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk_hex("rel2", 8'hC0, 8'hC0, 8'hC0, 8'hC0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
